// File: rtl/h14tx_island_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : h14tx_island_scheduler_if
//  Description : Packet beat stream from the HDMI 1.4 packet builder to the
//                Data Island scheduler. One beat per character, 32 beats per
//                packet, pre-BCH-coded nibbles.
//  Signals     : pkt_valid  builder -> scheduler  beat valid
//                pkt_ready  scheduler -> builder  beat accepted (valid&ready)
//                pkt_last   builder -> scheduler  beat 31 of the packet
//                pkt_hdr    builder -> scheduler  header bit for ch0 bit2
//                pkt_ch1    builder -> scheduler  subpacket nibble, channel 1
//                pkt_ch2    builder -> scheduler  subpacket nibble, channel 2
//  Modports    : master = packet builder, slave = scheduler
//  Revision    : 1.0  initial release
// ============================================================================
interface h14tx_island_scheduler_if;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic       pkt_hdr;
    logic [3:0] pkt_ch1;
    logic [3:0] pkt_ch2;

    modport master (
        output pkt_valid,
        output pkt_last,
        output pkt_hdr,
        output pkt_ch1,
        output pkt_ch2,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_last,
        input  pkt_hdr,
        input  pkt_ch1,
        input  pkt_ch2,
        output pkt_ready
    );
endinterface
`default_nettype wire

// File: rtl/h14tx_island_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : h14tx_island_scheduler
//  Description : HDMI 1.4 TX period scheduler. During blanking it opens Data
//                Island periods (preamble, leading guard band, 1..MAX_PKTS
//                32-character packets, trailing guard band) and feeds the
//                per-channel period select, CTL bits and TERC4 nibbles.
//  Parameters  : MAX_PKTS  packets per Data Island period (1..18)
//                MIN_CTRL  control characters required before a preamble
//  Macro       : H14TX_VIDEO_PREAMBLE_EN  adds the video preamble (8 chars,
//                CTL=0001) and video guard band (2 chars) ahead of active
//                video, and reserves 10 extra blanking characters for them.
//  Ports       : clk                pixel clock
//                rst_n              asynchronous active-low reset
//                de_i               video data enable
//                hsync_i, vsync_i   syncs, carried on ch0 bits 0/1
//                blank_remaining_i  blanking characters left before de_i rises
//                pkt_if             packet beat stream (slave side)
//                period_o           0 CTRL,1 VIDEO,2 VID_GUARD,3 DI_GUARD,4 DI_DATA
//                ctl_o              {CTL3..CTL0}, meaningful in CTRL periods
//                ch0_o..ch2_o       TERC4 nibbles per channel
//                err_o              one-cycle protocol-error pulse
//  Revision    : 1.0  initial release
// ============================================================================
module h14tx_island_scheduler #(
    parameter int MAX_PKTS = 18,
    parameter int MIN_CTRL = 4
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        de_i,
    input  wire        hsync_i,
    input  wire        vsync_i,
    input  wire [15:0] blank_remaining_i,
    h14tx_island_scheduler_if.slave pkt_if,
    output logic [2:0] period_o,
    output logic [3:0] ctl_o,
    output logic [3:0] ch0_o,
    output logic [3:0] ch1_o,
    output logic [3:0] ch2_o,
    output logic       err_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] PERIOD_CTRL      = 3'd0;
    localparam logic [2:0] PERIOD_VIDEO     = 3'd1;
    localparam logic [2:0] PERIOD_VID_GUARD = 3'd2;
    localparam logic [2:0] PERIOD_DI_GUARD  = 3'd3;
    localparam logic [2:0] PERIOD_DI_DATA   = 3'd4;

    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;
    localparam logic [3:0] CTL_VID_PRE = 4'b0001;

`ifdef H14TX_VIDEO_PREAMBLE_EN
    localparam int VID_OVH = 10;
`else
    localparam int VID_OVH = 0;
`endif

    // Blanking needed to open an island: 8 preamble + 2 guard + 32 packet
    // + 2 guard = 44, then MIN_CTRL control characters and the video lead-in.
    localparam logic [15:0] DI_START_MIN = 16'(44 + MIN_CTRL + VID_OVH);
    // Blanking needed at beat 31 to append one more packet: 32 + 2 guard.
    localparam logic [15:0] DI_NEXT_MIN  = 16'(34 + MIN_CTRL + VID_OVH);
    localparam logic [7:0]  CTRL_MIN     = 8'(MIN_CTRL);
    localparam logic [4:0]  PKTS_MAX     = 5'(MAX_PKTS);

    typedef enum logic [2:0] {
        S_CTRL    = 3'd0,
        S_DI_PRE  = 3'd1,
        S_DI_LGB  = 3'd2,
        S_DI_PKT  = 3'd3,
        S_DI_TGB  = 3'd4,
        S_VID_PRE = 3'd5,
        S_VID_GB  = 3'd6,
        S_VIDEO   = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_q,    state_d;
    logic [2:0] phase_q,    phase_d;     // character index inside preamble/guard
    logic [4:0] beat_q,     beat_d;      // authoritative packet framing
    logic [4:0] pkts_q,     pkts_d;      // packets opened in this island
    logic [7:0] ctrl_cnt_q, ctrl_cnt_d;  // consecutive CTRL characters, saturating

    logic [2:0] period_q,   period_d;
    logic [3:0] ctl_q,      ctl_d;
    logic [3:0] ch0_q,      ch0_d;
    logic [3:0] ch1_q,      ch1_d;
    logic [3:0] ch2_q,      ch2_d;
    logic       ready_q,    ready_d;
    logic       err_q,      err_d;

    logic       w_beat_last;
    logic       w_vid_pre_go;
    logic       w_abort;
    logic       w_abort_err;
    logic [1:0] w_sync;

    assign w_sync      = {vsync_i, hsync_i};
    assign w_beat_last = (beat_q == 5'd31);

    // de_i is only legitimately high in the video guard band or in video;
    // anywhere else it forces an immediate jump to VIDEO.
    assign w_abort = de_i && (state_q != S_VIDEO) && (state_q != S_VID_GB);

`ifdef H14TX_VIDEO_PREAMBLE_EN
    assign w_vid_pre_go = (blank_remaining_i == 16'd10);
    // With the video lead-in enabled every early de_i rise skipped it.
    assign w_abort_err  = 1'b1;
`else
    assign w_vid_pre_go = 1'b0;
    // Without a lead-in, CTRL->VIDEO on de_i is the normal video start;
    // only an interrupted island is an error.
    assign w_abort_err  = (state_q != S_CTRL);
`endif

    // ------------------------------------------------------------------
    // Next state and next outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        beat_d     = beat_q;
        pkts_d     = pkts_q;
        ctrl_cnt_d = 8'd0;
        period_d   = PERIOD_CTRL;
        ctl_d      = 4'd0;
        ch0_d      = {2'b00, w_sync};
        ch1_d      = 4'd0;
        ch2_d      = 4'd0;
        err_d      = 1'b0;

        case (state_q)
            S_CTRL: begin
                ctrl_cnt_d = (ctrl_cnt_q == 8'hFF) ? ctrl_cnt_q : ctrl_cnt_q + 8'd1;
                if (w_vid_pre_go) begin
                    state_d = S_VID_PRE;
                    phase_d = 3'd0;
                end else if ((ctrl_cnt_q >= CTRL_MIN) && pkt_if.pkt_valid &&
                             (blank_remaining_i >= DI_START_MIN)) begin
                    state_d = S_DI_PRE;
                    phase_d = 3'd0;
                end
            end

            S_DI_PRE: begin
                ctl_d   = CTL_DI_PRE;
                phase_d = phase_q + 3'd1;
                if (phase_q == 3'd7) begin
                    state_d = S_DI_LGB;
                    phase_d = 3'd0;
                end
            end

            S_DI_LGB: begin
                period_d = PERIOD_DI_GUARD;
                ch0_d    = {2'b11, w_sync};
                phase_d  = phase_q + 3'd1;
                if (phase_q == 3'd1) begin
                    state_d = S_DI_PKT;
                    phase_d = 3'd0;
                    beat_d  = 5'd0;
                    pkts_d  = 5'd1;
                end
            end

            S_DI_PKT: begin
                period_d = PERIOD_DI_DATA;
                // Bit 3 is first_n: low only on beat 0 of each packet.
                ch0_d    = {(beat_q != 5'd0), pkt_if.pkt_hdr, w_sync};
                if (pkt_if.pkt_valid) begin
                    ch1_d = pkt_if.pkt_ch1;
                    ch2_d = pkt_if.pkt_ch2;
                end
                // Blanking timing is fixed, so a missing beat is sent as zeros
                // and a wrong pkt_last is only flagged; framing follows beat_q.
                err_d  = !pkt_if.pkt_valid || (pkt_if.pkt_last != w_beat_last);
                beat_d = beat_q + 5'd1;
                if (w_beat_last) begin
                    if ((pkts_q < PKTS_MAX) && pkt_if.pkt_valid &&
                        (blank_remaining_i >= DI_NEXT_MIN)) begin
                        pkts_d = pkts_q + 5'd1;
                    end else begin
                        state_d = S_DI_TGB;
                        phase_d = 3'd0;
                    end
                end
            end

            S_DI_TGB: begin
                period_d = PERIOD_DI_GUARD;
                ch0_d    = {2'b11, w_sync};
                phase_d  = phase_q + 3'd1;
                if (phase_q == 3'd1) begin
                    state_d = S_CTRL;
                    phase_d = 3'd0;
                end
            end

            S_VID_PRE: begin
                ctl_d   = CTL_VID_PRE;
                phase_d = phase_q + 3'd1;
                if (phase_q == 3'd7) begin
                    state_d = S_VID_GB;
                    phase_d = 3'd0;
                end
            end

            S_VID_GB: begin
                period_d = PERIOD_VID_GUARD;
                phase_d  = phase_q + 3'd1;
                if (phase_q == 3'd1) begin
                    state_d = S_VIDEO;
                    phase_d = 3'd0;
                end
            end

            S_VIDEO: begin
                if (de_i) begin
                    period_d = PERIOD_VIDEO;
                end else begin
                    // de_i fell: this character is already blanking.
                    state_d = S_CTRL;
                end
            end

            default: begin
                state_d = S_CTRL;
            end
        endcase

        // A partially sent packet is simply dropped; the builder flushes
        // itself when it sees the video period.
        if (w_abort) begin
            state_d    = S_VIDEO;
            phase_d    = 3'd0;
            ctrl_cnt_d = 8'd0;
            period_d   = PERIOD_VIDEO;
            ctl_d      = 4'd0;
            ch0_d      = {2'b00, w_sync};
            ch1_d      = 4'd0;
            ch2_d      = 4'd0;
            err_d      = w_abort_err;
        end

        // Ready is registered one character ahead so it is high exactly
        // while the state register holds DI_PKT, i.e. while beats are taken.
        ready_d = (state_d == S_DI_PKT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CTRL;
            phase_q    <= 3'd0;
            beat_q     <= 5'd0;
            pkts_q     <= 5'd0;
            ctrl_cnt_q <= 8'd0;
            period_q   <= PERIOD_CTRL;
            ctl_q      <= 4'd0;
            ch0_q      <= 4'd0;
            ch1_q      <= 4'd0;
            ch2_q      <= 4'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            beat_q     <= beat_d;
            pkts_q     <= pkts_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            period_q   <= period_d;
            ctl_q      <= ctl_d;
            ch0_q      <= ch0_d;
            ch1_q      <= ch1_d;
            ch2_q      <= ch2_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign period_o         = period_q;
    assign ctl_o            = ctl_q;
    assign ch0_o            = ch0_q;
    assign ch1_o            = ch1_q;
    assign ch2_o            = ch2_q;
    assign err_o            = err_q;
    assign pkt_if.pkt_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_h14tx_island_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_h14tx_island_scheduler
//  Description : Self-checking bench for h14tx_island_scheduler. Each driven
//                character pushes its expected registered outputs into a
//                scoreboard queue; they are popped and compared one character
//                later. Honours H14TX_VIDEO_PREAMBLE_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_h14tx_island_scheduler;

    localparam int MIN_CTRL = 4;
    localparam int MAX_PKTS = 18;
`ifdef H14TX_VIDEO_PREAMBLE_EN
    localparam int VID_OVH = 10;
`else
    localparam int VID_OVH = 0;
`endif
    localparam int START_TH = 44 + MIN_CTRL + VID_OVH;

    localparam logic [2:0] P_CTRL  = 3'd0;
    localparam logic [2:0] P_VIDEO = 3'd1;
    localparam logic [2:0] P_VGB   = 3'd2;
    localparam logic [2:0] P_DIG   = 3'd3;
    localparam logic [2:0] P_DID   = 3'd4;

    typedef struct packed {
        logic [2:0] period;
        logic [3:0] ctl;
        logic [3:0] ch0;
        logic [3:0] ch1;
        logic [3:0] ch2;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] rem;
    logic [2:0]  period;
    logic [3:0]  ctl;
    logic [3:0]  ch0;
    logic [3:0]  ch1;
    logic [3:0]  ch2;
    logic        err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_chr = 0;

    h14tx_island_scheduler_if pif ();

    h14tx_island_scheduler #(
        .MAX_PKTS (MAX_PKTS),
        .MIN_CTRL (MIN_CTRL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .de_i              (de),
        .hsync_i           (hs),
        .vsync_i           (vs),
        .blank_remaining_i (rem),
        .pkt_if            (pif),
        .period_o          (period),
        .ctl_o             (ctl),
        .ch0_o             (ch0),
        .ch1_o             (ch1),
        .ch2_o             (ch2),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (char %0d): got %0h expected %0h", tag, n_chr, got, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("period", 8'(period), 8'(e.period));
            check("ctl",    8'(ctl),    8'(e.ctl));
            check("ch0",    8'(ch0),    8'(e.ch0));
            check("ch1",    8'(ch1),    8'(e.ch1));
            check("ch2",    8'(ch2),    8'(e.ch2));
            check("err",    8'(err),    8'(e.err));
        end
    endtask

    // One character: check the previous character's outputs, check ready for
    // this character, drive inputs and queue this character's expectation.
    task automatic step(input logic de_v, input logic [15:0] rem_v, input logic v,
                        input logic last, input logic hdr, input logic [3:0] c1,
                        input logic [3:0] c2, input logic erdy, input logic [2:0] ep,
                        input logic [3:0] ectl, input logic [1:0] e0hi,
                        input logic [3:0] e1, input logic [3:0] e2, input logic eerr);
        logic h;
        logic s;
        exp_t e;
        h = n_chr[1];
        s = n_chr[4];
        @(negedge clk);
        compare_head();
        check("ready", 8'(pif.pkt_ready), 8'(erdy));
        de            = de_v;
        rem           = rem_v;
        hs            = h;
        vs            = s;
        pif.pkt_valid = v;
        pif.pkt_last  = last;
        pif.pkt_hdr   = hdr;
        pif.pkt_ch1   = c1;
        pif.pkt_ch2   = c2;
        e.period = ep;
        e.ctl    = ectl;
        e.ch0    = {e0hi, s, h};
        e.ch1    = e1;
        e.ch2    = e2;
        e.err    = eerr;
        sb.push_back(e);
        n_chr++;
    endtask

    task automatic ctrl_chars(input int n, input logic [15:0] r, input logic v);
        for (int i = 0; i < n; i++)
            step(1'b0, r, v, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_CTRL, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic video_chars(input int n, input logic first_err);
        for (int i = 0; i < n; i++)
            step(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_VIDEO, 4'd0, 2'b00,
                 4'd0, 4'd0, (i == 0) && first_err);
    endtask

    // A whole island starting at a CTRL character with blanking r0 (counting
    // down one per character). npk packets are expected; drop/badlast/abrt
    // select a beat of the first packet to disturb (-1 = none).
    task automatic island(input int r0, input int npk, input int drop,
                          input int badlast, input int abrt);
        logic [15:0] r;
        logic        v;
        logic        last;
        logic        hdr;
        logic [3:0]  c1;
        logic [3:0]  c2;
        r = 16'(r0);
        step(1'b0, r, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_CTRL, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0);
        r = r - 16'd1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, r, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_CTRL, 4'b0101, 2'b00, 4'd0, 4'd0, 1'b0);
            r = r - 16'd1;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, r, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_DIG, 4'd0, 2'b11, 4'd0, 4'd0, 1'b0);
            r = r - 16'd1;
        end
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < 32; b++) begin
                hdr  = 1'(b ^ (p >> 1));
                c1   = 4'(b + p);
                c2   = ~4'(b ^ (p * 3));
                v    = !((p == 0) && (b == drop));
                last = (b == 31) ^ ((p == 0) && (b == badlast));
                if ((p == 0) && (b == abrt)) begin
                    step(1'b1, 16'd0, v, last, hdr, c1, c2, 1'b1, P_VIDEO, 4'd0, 2'b00,
                         4'd0, 4'd0, 1'b1);
                    return;
                end
                step(1'b0, r, v, last, hdr, c1, c2, 1'b1, P_DID, 4'd0, {(b != 0), hdr},
                     v ? c1 : 4'd0, v ? c2 : 4'd0, !v || (last != (b == 31)));
                r = r - 16'd1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, r, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_DIG, 4'd0, 2'b11, 4'd0, 4'd0, 1'b0);
            r = r - 16'd1;
        end
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        de = 1'b0; hs = 1'b1; vs = 1'b1; rem = 16'd1000;
        pif.pkt_valid = 1'b0; pif.pkt_last = 1'b0; pif.pkt_hdr = 1'b0;
        pif.pkt_ch1 = 4'd0; pif.pkt_ch2 = 4'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_period", 8'(period), 8'(P_CTRL));
        check("rst_ctl",    8'(ctl),    8'd0);
        check("rst_ch0",    8'(ch0),    8'd0);
        check("rst_ch1",    8'(ch1),    8'd0);
        check("rst_ch2",    8'(ch2),    8'd0);
        check("rst_ready",  8'(pif.pkt_ready), 8'd0);
        check("rst_err",    8'(err),    8'd0);
        rst_n = 1'b1;

        // Idle blanking, no packets offered
        ctrl_chars(20, 16'd1000, 1'b0);

        // One packet: blanking runs out for a second one
        island(START_TH + 20, 1, -1, -1, -1);
        ctrl_chars(6, 16'd1000, 1'b0);

        // One short of the start threshold: no island
        ctrl_chars(6, 16'(START_TH - 1), 1'b1);
        // Exactly the threshold: island starts
        island(START_TH, 1, -1, -1, -1);
        ctrl_chars(6, 16'd1000, 1'b0);

        // Packets offered continuously: capped at MAX_PKTS
        island(3000, MAX_PKTS, -1, -1, -1);
        ctrl_chars(6, 16'd1000, 1'b0);

        // Beat 10 missing and a wrong pkt_last at beat 20; length unchanged
        island(START_TH + 20, 1, 10, 20, -1);
        ctrl_chars(6, 16'd1000, 1'b0);

        // de_i rises at beat 5: immediate VIDEO with an error pulse
        island(1000, 1, -1, -1, 5);
        video_chars(4, 1'b0);
        ctrl_chars(6, 16'd1000, 1'b0);

`ifdef H14TX_VIDEO_PREAMBLE_EN
        // Video lead-in: 8 preamble characters, 2 guard, then video
        step(1'b0, 16'd10, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_CTRL, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 16'(9 - i), 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_CTRL, 4'b0001, 2'b00,
                 4'd0, 4'd0, 1'b0);
        step(1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_VGB, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0);
        step(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, P_VGB, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0);
        video_chars(4, 1'b0);
`else
        // Plain video start from blanking is not an error
        video_chars(4, 1'b0);
`endif
        ctrl_chars(4, 16'd1000, 1'b0);

        @(negedge clk);
        compare_head();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
